// File: rtl/seg_scan_decoder_pkg.sv
// Shared types and constants for the 7-segment scan decoder:
// FSM state encoding, active-low hex glyph table, blank pattern, anode helper.
package seg_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_t;

  // Active-low segment patterns for hex digits 0..F; bit 7 (dp) is don't-care.
  localparam logic [7:0] GLYPH [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  // All segments dark; never a valid digit.
  localparam logic [6:0] BLANK = 7'h7F;

  // Digit slot selected by an active-low one-hot anode vector.
  function automatic logic [2:0] an_index(input logic [7:0] an);
    an_index = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!an[i]) an_index = 3'(i);
    end
  endfunction

endpackage

// File: rtl/seg_scan_decoder_if.sv
// Bus bundle between the scanned display wires / decoded results and the decoder.
// master: the side driving SEG/AN and observing results; slave: the decoder.
interface seg_scan_decoder_if;
  logic [7:0]  SEG;
  logic [7:0]  AN;
  logic [31:0] value;
  logic [7:0]  dp;
  logic [7:0]  digit_valid;
  logic        frame_done;
  logic        glyph_err;
  logic        an_err;
  logic        timeout;

  modport master (
    output SEG, AN,
    input  value, dp, digit_valid, frame_done, glyph_err, an_err, timeout
  );

  modport slave (
    input  SEG, AN,
    output value, dp, digit_valid, frame_done, glyph_err, an_err, timeout
  );
endinterface

// File: rtl/seg_scan_decoder_glyph_decode.sv
// Combinational segment-pattern to hex-nibble lookup; hit=0 for anything
// that is not one of the 16 hex glyphs (including a blank digit).
module seg_glyph_decode
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic       hit,
  output logic [3:0] nibble
);

  // Table search; blank is forced to a miss even though it is not in the table.
  always_comb begin
    hit    = 1'b0;
    nibble = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (seg == GLYPH[i][6:0]) begin
        hit    = 1'b1;
        nibble = 4'(i);
      end
    end
    if (seg == BLANK) begin
      hit    = 1'b0;
      nibble = 4'h0;
    end
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Receive-side decoder for the multiplexed 7-segment bus. Registers SEG/AN,
// waits for a stable one-hot selection, captures each digit into a shadow
// word and publishes the word once all 8 digits of a frame are seen.
// Optional frame watchdog: define DECODER_TIMEOUT_EN.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input logic               clk,
  input logic               rst,
  seg_scan_decoder_if.slave bus
);

  localparam int unsigned   CW      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  logic [7:0]    s_seg, s_an;
  logic [CW-1:0] cnt, cnt_next;
  state_t        state, state_next;
  logic [7:0]    cap_seg, cap_an;
  logic [31:0]   shadow, value;
  logic [7:0]    shadow_dp, dp, digit_valid, an_act;
  logic          frame_done, glyph_err, an_err;
  logic          one_hot, multi_hot, hit, frame_full, capture_go;
  logic [3:0]    nibble;
  logic [2:0]    slot;

  assign an_act     = ~s_an;
  assign one_hot    = (an_act != 8'h00) && ((an_act & (an_act - 8'h01)) == 8'h00);
  assign multi_hot  = (an_act != 8'h00) && !one_hot;
  assign slot       = an_index(cap_an);
  assign frame_full = (digit_valid == 8'hFF);
  assign capture_go = (state == SETTLE) && (state_next == CAPTURE);

  seg_glyph_decode u_glyph (
    .seg    (cap_seg[6:0]),
    .hit    (hit),
    .nibble (nibble)
  );

`ifdef DECODER_TIMEOUT_EN
  localparam int unsigned   WW      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);
  logic [WW-1:0] wd;
  logic          timeout;
`endif

  // Run length of the registered sample: restarts whenever the incoming sample differs.
  always_comb begin
    cnt_next = '0;
    if ({bus.SEG, bus.AN} == {s_seg, s_an})
      cnt_next = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
  end

  // Digit acquisition sequencing; a multi-hot anode aborts to IDLE from anywhere.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (one_hot) state_next = SETTLE;
      SETTLE:  if (!one_hot) state_next = IDLE;
               else if (cnt_next == CNT_MAX) state_next = CAPTURE;
      CAPTURE: state_next = HOLD;
      HOLD:    if (s_an != cap_an) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (multi_hot) state_next = IDLE;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Input sampling, digit capture, frame publication, sticky errors and watchdog.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s_seg       <= 8'hFF;
      s_an        <= 8'hFF;
      cnt         <= '0;
      cap_seg     <= 8'hFF;
      cap_an      <= 8'hFF;
      shadow      <= '0;
      shadow_dp   <= '0;
      value       <= '0;
      dp          <= '0;
      digit_valid <= '0;
      frame_done  <= 1'b0;
      glyph_err   <= 1'b0;
      an_err      <= 1'b0;
`ifdef DECODER_TIMEOUT_EN
      wd          <= '0;
      timeout     <= 1'b0;
`endif
    end else begin
      s_seg      <= bus.SEG;
      s_an       <= bus.AN;
      cnt        <= cnt_next;
      frame_done <= frame_full;
      if (multi_hot) an_err <= 1'b1;
      // Freeze the stable sample so a change during CAPTURE cannot leak in.
      if (capture_go) begin
        cap_seg <= s_seg;
        cap_an  <= s_an;
      end
      if (state == CAPTURE) begin
        shadow[slot*4 +: 4] <= nibble;
        shadow_dp[slot]     <= ~cap_seg[7];
        digit_valid[slot]   <= 1'b1;
        if (!hit) glyph_err <= 1'b1;
      end
      if (frame_full) begin
        value       <= shadow;
        dp          <= shadow_dp;
        digit_valid <= '0;
      end
`ifdef DECODER_TIMEOUT_EN
      timeout <= 1'b0;
      if (frame_full) begin
        wd <= '0;
      end else if (wd == WD_LAST) begin
        wd          <= '0;
        timeout     <= 1'b1;
        digit_valid <= '0;
      end else begin
        wd <= wd + WW'(1);
      end
`endif
    end
  end

  assign bus.value       = value;
  assign bus.dp          = dp;
  assign bus.digit_valid = digit_valid;
  assign bus.frame_done  = frame_done;
  assign bus.glyph_err   = glyph_err;
  assign bus.an_err      = an_err;
`ifdef DECODER_TIMEOUT_EN
  assign bus.timeout = timeout;
`else
  // Without the watchdog the timeout length has no effect.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign bus.timeout = 1'b0;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: digit-level reference model pushes
// expected frames; a negedge monitor pops and compares on each frame_done.
module tb_seg_scan_decoder;

  localparam int S   = 4;
  localparam int TO  = 256;
  localparam int DIG = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seg_scan_decoder_if bus();

  seg_scan_decoder #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] glyph_tab [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef struct {
    logic [31:0] value;
    logic [7:0]  dp;
    logic        gerr;
    logic        aerr;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int n_checks = 0, n_fail = 0, cyc = 0, to_pulses = 0, exp_to = 0;

  // Reference model state (digit level)
  logic [3:0]  m_nib [8];
  logic [7:0]  m_dp = '0, m_mask = '0;
  logic        m_gerr = 1'b0, m_aerr = 1'b0;
  logic [31:0] m_value = '0;

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // Monitor: compare each published frame against the oldest expectation.
  always @(negedge clk) begin
    if (bus.timeout === 1'b1) to_pulses++;
    if (rst && bus.frame_done === 1'b1) begin
      if (q.size() == 0) begin
        check("frame_done_spurious", {31'd0, bus.frame_done}, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("frame_value", bus.value, e.value);
        check("frame_dp", {24'd0, bus.dp}, {24'd0, e.dp});
        check("frame_glyph_err", {31'd0, bus.glyph_err}, {31'd0, e.gerr});
        check("frame_an_err", {31'd0, bus.an_err}, {31'd0, e.aerr});
        check("frame_latency", cyc, e.cyc);
      end
    end
  end

  task automatic model_capture(input int idx, input logic [7:0] seg, input int start);
    logic hit;
    logic [3:0] nib;
    exp_t e;
    hit = 1'b0;
    nib = 4'h0;
    for (int g = 0; g < 16; g++)
      if (glyph_tab[g][6:0] == seg[6:0]) begin hit = 1'b1; nib = 4'(g); end
    if (!hit) m_gerr = 1'b1;
    m_nib[idx]  = nib;
    m_dp[idx]   = ~seg[7];
    m_mask[idx] = 1'b1;
    if (m_mask == 8'hFF) begin
      e.value = '0;
      for (int k = 0; k < 8; k++) e.value[k*4 +: 4] = m_nib[k];
      e.dp   = m_dp;
      e.gerr = m_gerr;
      e.aerr = m_aerr;
      e.cyc  = start + S + 3;
      q.push_back(e);
      m_value = e.value;
      m_mask  = '0;
    end
  endtask

  // Called at posedge+1; leaves at posedge+1 after n edges.
  task automatic set_wait(input logic [7:0] seg, input logic [7:0] an, input int n);
    bus.SEG = seg;
    bus.AN  = an;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_digit(input int idx, input logic [7:0] seg, input bit glitch);
    logic [7:0] an;
    int start;
    an    = ~(8'h01 << idx);
    start = cyc;
    if (glitch) begin
      set_wait(8'h80, an, 2);
      if (seg != 8'h80) start = cyc;
    end
    model_capture(idx, seg, start);
    set_wait(seg, an, glitch ? DIG - 2 : DIG);
    check("digit_valid", {24'd0, bus.digit_valid}, {24'd0, m_mask});
  endtask

  task automatic build(input logic [31:0] v, input logic [7:0] d, output logic [7:0] segs [8]);
    for (int i = 0; i < 8; i++) segs[i] = {~d[i], glyph_tab[v[i*4 +: 4]][6:0]};
  endtask

  task automatic scan(input logic [7:0] segs [8], input bit shuffle, input bit glitch, input int ndig);
    int ord [8];
    int tmp;
    for (int i = 0; i < 8; i++) ord[i] = 7 - i;
    if (shuffle) begin
      for (int i = 7; i > 0; i--) begin
        int j;
        j = int'($urandom_range(i, 0));
        tmp = ord[i]; ord[i] = ord[j]; ord[j] = tmp;
      end
    end
    set_wait(8'hFF, 8'hFF, 3);
    for (int i = 0; i < ndig; i++) drive_digit(ord[i], segs[ord[i]], glitch);
  endtask

  task automatic rand_frame(input bit glitch);
    logic [7:0] segs [8];
    build($urandom, 8'($urandom), segs);
    scan(segs, 1'b1, glitch, 8);
  endtask

  task automatic check_reset_state();
    check("rst_value", bus.value, 32'd0);
    check("rst_dp", {24'd0, bus.dp}, 32'd0);
    check("rst_digit_valid", {24'd0, bus.digit_valid}, 32'd0);
    check("rst_flags", {28'd0, bus.frame_done, bus.glyph_err, bus.an_err, bus.timeout}, 32'd0);
  endtask

  initial begin
    logic [7:0] segs [8];
    bit seen;
    bus.SEG = 8'hFF;
    bus.AN  = 8'hFF;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state();
    rst = 1'b1;

    // 1: plain scan of "1234ABCD"
    build(32'h1234ABCD, 8'h00, segs);
    scan(segs, 1'b0, 1'b0, 8);
    // 2: same scan with a 2-cycle '8' glitch at each digit start
    scan(segs, 1'b0, 1'b1, 8);
    for (int f = 0; f < 4; f++) rand_frame(f[0]);

    // 3: unknown glyph (blank) on digit 3
    segs[3] = 8'hFF;
    scan(segs, 1'b0, 1'b0, 8);
    rand_frame(1'b0);

    // 4: two anodes active mid-scan, then a full scan completes the frame
    build($urandom, 8'($urandom), segs);
    scan(segs, 1'b0, 1'b0, 4);
    set_wait(8'hC0, 8'hFC, 10);
    m_aerr = 1'b1;
    check("an_err_sticky", {31'd0, bus.an_err}, 32'd1);
    check("an_err_no_capture", {24'd0, bus.digit_valid}, {24'd0, m_mask});
    rand_frame(1'b0);

    // 5: reset in the middle of a frame
    build($urandom, 8'($urandom), segs);
    scan(segs, 1'b1, 1'b0, 5);
    rst = 1'b0;
    set_wait(8'hFF, 8'hFF, 2);
    check_reset_state();
    rst = 1'b1;
    m_mask = '0; m_gerr = 1'b0; m_aerr = 1'b0; m_value = '0;
    for (int f = 0; f < 3; f++) rand_frame(f[1]);

`ifdef DECODER_TIMEOUT_EN
    // 6: stall after 4 digits until the watchdog fires
    build($urandom, 8'($urandom), segs);
    scan(segs, 1'b0, 1'b0, 4);
    bus.AN = 8'hFF;
    seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      if (bus.timeout === 1'b1) seen = 1'b1;
    end
    exp_to = 1;
    check("timeout_seen", {31'd0, seen}, 32'd1);
    check("timeout_digit_valid", {24'd0, bus.digit_valid}, 32'd0);
    check("timeout_value_kept", bus.value, m_value);
    @(negedge clk);
    check("timeout_pulse_width", {31'd0, bus.timeout}, 32'd0);
    m_mask = '0;
    @(posedge clk);
    #1;
`else
    seen = 1'b0;
`endif

    // Drain outstanding expectations with a bounded wait
    for (int k = 0; k < 100 && q.size() != 0; k++) @(posedge clk);
    #1;
    check("queue_drained", q.size(), 32'd0);
    check("timeout_pulses", to_pulses, exp_to);
    check("final_an_err", {31'd0, bus.an_err}, {31'd0, m_aerr});
    check("final_glyph_err", {31'd0, bus.glyph_err}, {31'd0, m_gerr});
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
